// File: rtl/ed25519_pkg.sv
// ed25519_pkg: coordinate width, identity point (0,1,1,0) and extended-coordinate point type
package ed25519_pkg;
  localparam int ED_W = 256;
  localparam logic [ED_W-1:0] ID_X = '0;
  localparam logic [ED_W-1:0] ID_Y = ED_W'(1);
  localparam logic [ED_W-1:0] ID_Z = ED_W'(1);
  localparam logic [ED_W-1:0] ID_T = '0;
  typedef struct packed {
    logic [ED_W-1:0] x;
    logic [ED_W-1:0] y;
    logic [ED_W-1:0] z;
    logic [ED_W-1:0] t;
  } point_t;
endpackage

// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: MSB-first double-and-always-add k*P sequencer; i_start/i_scalar/i_p* in, o_busy/o_finished/o_x..o_t out, o_pa_*/i_pa_* drive an external PointAdd
module scalar_mult_ctrl
  import ed25519_pkg::*;
#(
  parameter int W = ED_W,
  parameter int SCALAR_W = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [SCALAR_W-1:0] i_scalar,
  input  logic [W-1:0]        i_px,
  input  logic [W-1:0]        i_py,
  input  logic [W-1:0]        i_pz,
  input  logic [W-1:0]        i_pt,
  output logic                o_busy,
  output logic                o_finished,
  output logic [W-1:0]        o_x,
  output logic [W-1:0]        o_y,
  output logic [W-1:0]        o_z,
  output logic [W-1:0]        o_t,
  output logic                o_pa_start,
  output logic                o_pa_doubling,
  output logic [W-1:0]        o_pa_x1,
  output logic [W-1:0]        o_pa_y1,
  output logic [W-1:0]        o_pa_z1,
  output logic [W-1:0]        o_pa_t1,
  output logic [W-1:0]        o_pa_x2,
  output logic [W-1:0]        o_pa_y2,
  output logic [W-1:0]        o_pa_z2,
  output logic [W-1:0]        o_pa_t2,
  input  logic [W-1:0]        i_pa_x3,
  input  logic [W-1:0]        i_pa_y3,
  input  logic [W-1:0]        i_pa_z3,
  input  logic [W-1:0]        i_pa_t3,
  input  logic                i_pa_finished
);
  localparam int IW = SCALAR_W > 1 ? $clog2(SCALAR_W) : 1;
  typedef enum logic [2:0] {IDLE, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE} state_t;
  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] t;
  } pt_t;
  localparam pt_t IDENT = {W'(ID_X), W'(ID_Y), W'(ID_Z), W'(ID_T)};
  state_t state, state_n;
  pt_t r, r_n, p, op1, op2, res;
  logic [SCALAR_W-1:0] k;
  logic [IW-1:0] idx, idx_n;
  logic last;
  assign res = {i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3};
  assign last = idx == '0;
  always_comb begin
    state_n = state;
    r_n = r;
    idx_n = idx;
    unique case (state)
      IDLE: if (i_start) begin
        state_n = DBL_REQ;
        r_n = IDENT;
        idx_n = IW'(SCALAR_W - 1);
      end
      DBL_REQ: state_n = DBL_WAIT;
      DBL_WAIT: if (i_pa_finished) begin
        state_n = ADD_REQ;
        r_n = res;
      end
      ADD_REQ: state_n = ADD_WAIT;
      ADD_WAIT: if (i_pa_finished) begin
        // the add always runs so timing is scalar-independent; k selects whether it sticks
        r_n = k[idx] ? res : r;
        state_n = last ? DONE : DBL_REQ;
        idx_n = last ? idx : idx - 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      r <= IDENT;
      idx <= '0;
      k <= '0;
      p <= '0;
      op1 <= '0;
      op2 <= '0;
    end else begin
      state <= state_n;
      r <= r_n;
      idx <= idx_n;
      if (state == IDLE && i_start) begin
        k <= i_scalar;
        p <= {i_px, i_py, i_pz, i_pt};
      end
      // operands load on entry to a REQ state and stay put until the WAIT completes
      if (state_n == DBL_REQ) begin
        op1 <= r_n;
        op2 <= r_n;
      end
      if (state_n == ADD_REQ) begin
        op1 <= r_n;
        op2 <= p;
      end
    end
  end
  assign o_busy = state != IDLE;
  assign o_finished = state == DONE;
  assign o_pa_start = state == DBL_REQ || state == ADD_REQ;
  assign o_pa_doubling = state == DBL_REQ || state == DBL_WAIT;
  assign {o_x, o_y, o_z, o_t} = r;
  assign {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_t1} = op1;
  assign {o_pa_x2, o_pa_y2, o_pa_z2, o_pa_t2} = op2;
endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// tb_scalar_mult_ctrl: scoreboard bench with an additive mock PointAdd (L=3) and k*P reference model
module tb_scalar_mult_ctrl;
  localparam int W = 256;
  localparam int SW = 8;
  localparam int L = 3;
  typedef struct {
    logic [W-1:0] x, y, z, t;
    int c0;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, pa_fin = 0;
  logic [SW-1:0] k = '0;
  logic [W-1:0] px = '0, py = '0, pz = '0, pt = '0;
  logic busy, fin, pa_start, pa_dbl;
  logic [W-1:0] ox, oy, oz, ot, x1, y1, z1, t1, x2, y2, z2, t2;
  logic [W-1:0] x3 = '0, y3 = '0, z3 = '0, t3 = '0;
  logic [W-1:0] cur_px = '0, cur_py = '0, cur_pz = '0, cur_pt = '0;
  int checks = 0, failures = 0, cyc = 0, nstarts = 0, hold_len = 1, cnt = 1000;
  bit exp_dbl = 1;
  exp_t q[$];

  scalar_mult_ctrl #(.W(W), .SCALAR_W(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_scalar(k),
    .i_px(px), .i_py(py), .i_pz(pz), .i_pt(pt),
    .o_busy(busy), .o_finished(fin),
    .o_x(ox), .o_y(oy), .o_z(oz), .o_t(ot),
    .o_pa_start(pa_start), .o_pa_doubling(pa_dbl),
    .o_pa_x1(x1), .o_pa_y1(y1), .o_pa_z1(z1), .o_pa_t1(t1),
    .o_pa_x2(x2), .o_pa_y2(y2), .o_pa_z2(z2), .o_pa_t2(t2),
    .i_pa_x3(x3), .i_pa_y3(y3), .i_pa_z3(z3), .i_pa_t3(t3),
    .i_pa_finished(pa_fin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // mock PointAdd: finished L cycles after a start, held hold_len cycles unless a new start arrives
  initial forever begin
    @(posedge clk); #2;
    if (rst) cnt = 1000;
    else if (pa_start) begin
      cnt = 0;
      x3 = x1 + x2;
      t3 = t1 + t2;
      y3 = y1;
      z3 = z1;
    end else if (cnt < 1000) cnt++;
    pa_fin = cnt >= L && cnt < L + hold_len;
  end

  // monitor: request sequencing and result scoreboard
  initial forever begin
    @(posedge clk); #2;
    if (pa_start) begin
      chk("pa_doubling", W'(pa_dbl), W'(exp_dbl));
      if (!exp_dbl) begin
        chk("add_op2_x", x2, cur_px);
        chk("add_op2_y", y2, cur_py);
        chk("add_op2_z", z2, cur_pz);
        chk("add_op2_t", t2, cur_pt);
      end
      exp_dbl = !exp_dbl;
      nstarts++;
    end
    if (fin) begin
      chk("finish_expected", W'(q.size() > 0), W'(1));
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("res_x", ox, e.x);
        chk("res_y", oy, e.y);
        chk("res_z", oz, e.z);
        chk("res_t", ot, e.t);
        chk("latency", W'(cyc - e.c0), W'(1 + 2 * SW * (L + 1)));
      end
    end
  end

  task automatic issue(logic [SW-1:0] kk, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic [W-1:0] d);
    exp_t e;
    @(posedge clk); #1;
    start = 1; k = kk; px = a; py = b; pz = c; pt = d;
    cur_px = a; cur_py = b; cur_pz = c; cur_pt = d;
    exp_dbl = 1;
    nstarts = 0;
    // mock adds x and t, passes y and z from operand 1 (R starts at y=z=1)
    e.x = W'(kk) * a;
    e.y = W'(1);
    e.z = W'(1);
    e.t = W'(kk) * d;
    e.c0 = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      got = fin;
    end
    chk("finish_timeout", W'(got), W'(1));
    chk("pa_start_count", W'(nstarts), W'(2 * SW));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_finished", W'(fin), '0);
    chk("rst_pa_start", W'(pa_start), '0);
    chk("rst_pa_doubling", W'(pa_dbl), '0);
    chk("rst_x", ox, '0);
    chk("rst_y", oy, W'(1));
    chk("rst_z", oz, W'(1));
    chk("rst_t", ot, '0);
    chk("rst_op1", x1 | y1 | z1 | t1, '0);
    chk("rst_op2", x2 | y2 | z2 | t2, '0);
    rst = 0;

    issue(8'h05, W'(7), W'(1), W'(1), W'(3));
    wait_done();
    issue(8'h00, W'(9), W'(1), W'(1), W'(9));
    wait_done();
    issue(8'hFF, W'(1), W'(1), W'(1), rand_w());
    wait_done();
    issue(8'h02, {1'b1, {(W-1){1'b0}}}, W'(1), W'(1), W'(5));
    wait_done();

    // starts at cycle 10 and at the DONE cycle must be ignored
    issue(8'h5A, rand_w(), W'(1), W'(1), rand_w());
    repeat (9) begin @(posedge clk); #1; end
    start = 1; k = 8'hAA; px = rand_w();
    @(posedge clk); #1;
    start = 0;
    wait_done();
    start = 1; k = 8'h33;
    @(posedge clk); #1;
    start = 0;
    chk("done_start_ignored", W'(busy), '0);
    repeat (80) @(posedge clk);

    // finished strobe held high for several cycles
    hold_len = 4;
    issue(8'h05, W'(7), W'(1), W'(1), W'(3));
    wait_done();
    hold_len = 1;

    // reset mid-operation
    issue(8'hC3, rand_w(), W'(1), W'(1), rand_w());
    repeat (29) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    nstarts = 0;
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_pa_start", W'(pa_start), '0);
    chk("midrst_x", ox, '0);
    chk("midrst_y", oy, W'(1));
    chk("midrst_z", oz, W'(1));
    chk("midrst_t", ot, '0);
    chk("midrst_op1_x", x1, '0);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_request", W'(nstarts), '0);
    issue(8'h81, rand_w(), W'(1), W'(1), rand_w());
    wait_done();

    // random back-to-back runs, each accepted the cycle after the previous o_finished
    for (int n = 0; n < 5; n++) begin
      issue(SW'($urandom), rand_w(), rand_w(), rand_w(), rand_w());
      wait_done();
    end
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", W'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
